generic_mem_sync_be: RTL and testbench
======================================

Name: generic_mem_sync_be

Overview:
- Single-clock simple-dual-port RAM: one write port with per-byte-lane enables, one read port with a pipelined read path.
- Each returned word is tagged with a valid pulse.
- Read-during-write behaviour is selectable.
- Next-generation buffer memory under the generic_fifo and xge_mac datapath blocks, where 64-bit lanes need partial writes and a known read latency.

Parameters:
- DWIDTH, 64, data width in bits; must be a multiple of BWIDTH (elaboration error otherwise).
- BWIDTH, 8, bits per byte lane; NLANES = DWIDTH/BWIDTH.
- AWIDTH, 4, address width.
- RAM_DEPTH, 1<<AWIDTH, number of words; may be less than 2^AWIDTH.
- REGISTER_READ, 0, 0 = read latency 1; 1 = extra output register gated by roen, latency 2.
- RDW_MODE, 0, same-address read/write in one cycle: 0 = old data, 1 = new (merged) data.

Ports:
- clk, in, 1, single clock; all logic on posedge.
- rst_n, in, 1, asynchronous active-low reset.
- wen, in, 1, write strobe.
- waddr, in, AWIDTH, write address.
- wdata, in, DWIDTH, write data.
- wbe, in, NLANES, byte-lane write enables; bit i covers wdata[i*BWIDTH +: BWIDTH].
- ren, in, 1, read strobe.
- raddr, in, AWIDTH, read address.
- roen, in, 1, output register enable (used only when REGISTER_READ=1).
- rdata, out, DWIDTH, read data.
- rvalid, out, 1, rdata holds the result of a read.
- rd_ovr, out, 1, sticky: a stage-1 read result was lost.

Behaviour:
- Reset (async assert, synchronous deassert by the integrator):
  - Cleared: rdata, rvalid, rd_ovr, stage-1 data/valid, stage-2 data/valid.
  - RAM array is not reset; contents are undefined until written.
- Write:
  - On posedge with wen=1 and waddr<RAM_DEPTH, each lane i with wbe[i]=1 takes its wdata lane.
  - Other lanes are untouched.
  - wen=1 with wbe=0 is a no-op.
  - waddr>=RAM_DEPTH: write dropped.
- Stage 1:
  - On posedge, s1_valid <= ren.
  - If ren=1: s1_data <= mem[raddr], or all-zero if raddr>=RAM_DEPTH.
  - If ren=0: s1_data holds.
- Same-cycle wen && ren && waddr==raddr (in range):
  - RDW_MODE=0: s1_data = pre-write contents.
  - RDW_MODE=1: lanes with wbe=1 return wdata; other lanes return the old contents.
- REGISTER_READ=0:
  - rdata = s1_data, rvalid = s1_valid; 1-cycle latency.
  - roen is ignored; rd_ovr stays 0.
- REGISTER_READ=1, roen=1: s2_data <= s1_data and s2_valid <= s1_valid.
- REGISTER_READ=1, roen=0 (stall): s2 holds, so rvalid stays asserted if it was set.
- REGISTER_READ=1 outputs: rdata = s2_data, rvalid = s2_valid; 2-cycle latency with roen held high.
- Stall rule (REGISTER_READ=1): caller must not issue ren while roen=0 and s1_valid=1.
  - If it does, the s1 result is overwritten, rd_ovr is set and stays set until rst_n.
- Reset during an outstanding read: the read is dropped; no rvalid is produced.
- Back-to-back reads: one result per cycle, in issue order.

Decomposition:
- Shared package generic_mem_pkg holds:
  - NLANES derivation function.
  - Lane-merge function (old, new, be), reused by the RDW_MODE=1 forwarding path and the write path.
  - RDW_OLD/RDW_NEW constants.
- One sub-module: generic_mem_rd_pipe.
  - Contains the stage-1/stage-2 registers, valid tracking and the rd_ovr detector.
  - Parametrised on DWIDTH and REGISTER_READ.
- The array and write logic stay in the top module so synthesis infers block RAM.

Test Plan:
- Full write/readback:
  - DWIDTH=64, REGISTER_READ=0: write 0x1111_2222_3333_4444 at addr 3 with wbe=0xFF.
  - ren at addr 3 next cycle -> rvalid=1 one cycle later, rdata=0x1111_2222_3333_4444.
- Partial lane write:
  - Write 0xAAAA_AAAA_AAAA_AAAA at addr 5 with wbe=0xFF, then 0x0 with wbe=0x0F.
  - Read addr 5 -> 0xAAAA_AAAA_0000_0000.
- Read-during-write, old data:
  - addr 7 holds 0x00FF; same cycle wen/ren addr 7, wdata=0x1234, wbe=0xFF, RDW_MODE=0.
  - Response -> 0x00FF; next read -> 0x1234.
- Read-during-write, merged:
  - RDW_MODE=1, addr 2 holds 0xFFFF_FFFF_FFFF_FFFF; same-cycle write 0 with wbe=0x01.
  - Response -> 0xFFFF_FFFF_FFFF_FF00.
- Latency, stall and overrun (REGISTER_READ=1):
  - Reads at addr 0,1,2 on consecutive cycles with roen=1 -> rvalid on cycles 2,3,4 in order.
  - Drop roen with s1 valid, issue ren -> rd_ovr=1, held until rst_n.
- Async reset and out-of-range access:
  - Assert rst_n low between clock edges with rvalid=1 -> rdata=0, rvalid=0, rd_ovr=0 immediately.
  - RAM_DEPTH=12: write addr 13 is dropped; read addr 13 -> rdata=0, rvalid=1.

Source files
------------

// File: rtl/generic_mem_pkg.sv
// Shared helpers for the byte-enabled buffer memory: lane count, lane merge, RDW modes.
// Pure functions and constants; no state, no latency, no flow control.
package generic_mem_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Widest word lane_merge accepts; callers zero-extend into it and truncate back.
    localparam int MERGE_W = 1024;

    function automatic int calc_nlanes(input int dwidth, input int bwidth);
        return dwidth / bwidth;
    endfunction

    function automatic logic [MERGE_W-1:0] lane_merge(
        input logic [MERGE_W-1:0] old_w,
        input logic [MERGE_W-1:0] new_w,
        input logic [MERGE_W-1:0] be,
        input int                 bwidth
    );
        logic [MERGE_W-1:0] res;
        res = old_w;
        for (int b = 0; b < MERGE_W; b++) begin
            if (be[b / bwidth]) begin
                res[b] = new_w[b];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/generic_mem_rd_pipe.sv
// Read return pipeline: stage-1 capture, optional roen-gated stage-2, sticky overrun flag.
// Latency 1 (REGISTER_READ=0) or 2 (REGISTER_READ=1, roen high).
// roen=0 freezes stage 2; a stalled result waits in stage 1 until a new read overwrites it.
module generic_mem_rd_pipe #(
    parameter int DWIDTH        = 64,
    parameter int REGISTER_READ = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ren,
    input  logic [DWIDTH-1:0] rd_word,
    input  logic              roen,
    output logic [DWIDTH-1:0] rdata,
    output logic              rvalid,
    output logic              rd_ovr
);

    logic [DWIDTH-1:0] s1_data_q, s1_data_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_hold;

    always_comb begin
        s1_data_d  = s1_data_q;
        s1_valid_d = ren || s1_hold;
        if (ren) begin
            s1_data_d = rd_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_data_q  <= s1_data_d;
            s1_valid_q <= s1_valid_d;
        end
    end

    if (REGISTER_READ != 0) begin : g_reg
        logic [DWIDTH-1:0] s2_data_q, s2_data_d;
        logic              s2_valid_q, s2_valid_d;
        logic              ovr_q, ovr_d;

        assign s1_hold = s1_valid_q && !roen;

        always_comb begin
            s2_data_d  = s2_data_q;
            s2_valid_d = s2_valid_q;
            if (roen) begin
                s2_data_d  = s1_data_q;
                s2_valid_d = s1_valid_q;
            end
            ovr_d = ovr_q || (ren && !roen && s1_valid_q);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_data_q  <= '0;
                s2_valid_q <= 1'b0;
                ovr_q      <= 1'b0;
            end else begin
                s2_data_q  <= s2_data_d;
                s2_valid_q <= s2_valid_d;
                ovr_q      <= ovr_d;
            end
        end

        assign rdata  = s2_data_q;
        assign rvalid = s2_valid_q;
        assign rd_ovr = ovr_q;
    end else begin : g_noreg
        logic unused_roen;

        assign s1_hold     = 1'b0;
        assign unused_roen = roen;
        assign rdata       = s1_data_q;
        assign rvalid      = s1_valid_q;
        assign rd_ovr      = 1'b0;
    end

endmodule

// File: rtl/generic_mem_sync_be.sv
// Simple-dual-port buffer RAM with byte-lane write enables and a pipelined, valid-tagged read.
// Read latency 1 or 2 (REGISTER_READ); out-of-range reads return zero, out-of-range writes drop.
// No write backpressure; reads stall only via roen when the output register is present.
module generic_mem_sync_be
    import generic_mem_pkg::*;
#(
    parameter int  DWIDTH        = 64,
    parameter int  BWIDTH        = 8,
    parameter int  AWIDTH        = 4,
    parameter int  RAM_DEPTH     = 1 << AWIDTH,
    parameter int  REGISTER_READ = 0,
    parameter int  RDW_MODE      = RDW_OLD,
    localparam int NLANES        = calc_nlanes(DWIDTH, BWIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wen,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [NLANES-1:0] wbe,
    input  logic              ren,
    input  logic [AWIDTH-1:0] raddr,
    input  logic              roen,
    output logic [DWIDTH-1:0] rdata,
    output logic              rvalid,
    output logic              rd_ovr
);

    localparam int IDXW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    if (DWIDTH % BWIDTH != 0) begin : g_bad_lanes
        $error("generic_mem_sync_be: DWIDTH must be a multiple of BWIDTH");
    end
    if (RAM_DEPTH > (1 << AWIDTH) || RAM_DEPTH < 1) begin : g_bad_depth
        $error("generic_mem_sync_be: RAM_DEPTH must lie in 1 .. 2**AWIDTH");
    end

    logic [DWIDTH-1:0] mem [RAM_DEPTH];

    logic              wr_hit;
    logic              rd_hit;
    logic              rdw_hit;
    logic [IDXW-1:0]   widx;
    logic [IDXW-1:0]   ridx;
    logic [DWIDTH-1:0] wr_word;
    logic [DWIDTH-1:0] rd_word;

    assign widx    = waddr[IDXW-1:0];
    assign ridx    = raddr[IDXW-1:0];
    assign wr_hit  = wen && (int'(waddr) < RAM_DEPTH) && (wbe != '0);
    assign rd_hit  = int'(raddr) < RAM_DEPTH;
    assign rdw_hit = wr_hit && (waddr == raddr);

    // Merged word is the new row value and doubles as the new-data bypass.
    assign wr_word = DWIDTH'(lane_merge(MERGE_W'(mem[widx]), MERGE_W'(wdata),
                                        MERGE_W'(wbe), BWIDTH));

    always_ff @(posedge clk) begin
        if (wr_hit) begin
            mem[widx] <= wr_word;
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_hit) begin
            rd_word = mem[ridx];
            if (RDW_MODE == RDW_NEW && rdw_hit) begin
                rd_word = wr_word;
            end
        end
    end

    generic_mem_rd_pipe #(
        .DWIDTH        (DWIDTH),
        .REGISTER_READ (REGISTER_READ)
    ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .ren     (ren),
        .rd_word (rd_word),
        .roen    (roen),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .rd_ovr  (rd_ovr)
    );

endmodule

// File: tb/tb_generic_mem_sync_be.sv
// Directed bench: three memory variants (old-data/depth 12, merged RDW, registered read)
// share one stimulus bus; each check names the variant it observes.
module tb_generic_mem_sync_be;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wen;
    logic [3:0]  waddr;
    logic [63:0] wdata;
    logic [7:0]  wbe;
    logic        ren;
    logic [3:0]  raddr;
    logic        roen;

    logic [63:0] rdata_a, rdata_b, rdata_c;
    logic        rvalid_a, rvalid_b, rvalid_c;
    logic        rd_ovr_a, rd_ovr_b, rd_ovr_c;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    generic_mem_sync_be #(.DWIDTH(64), .BWIDTH(8), .AWIDTH(4), .RAM_DEPTH(12),
                          .REGISTER_READ(0), .RDW_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .ren(ren), .raddr(raddr), .roen(roen),
        .rdata(rdata_a), .rvalid(rvalid_a), .rd_ovr(rd_ovr_a)
    );

    generic_mem_sync_be #(.DWIDTH(64), .BWIDTH(8), .AWIDTH(4), .RAM_DEPTH(16),
                          .REGISTER_READ(0), .RDW_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .ren(ren), .raddr(raddr), .roen(roen),
        .rdata(rdata_b), .rvalid(rvalid_b), .rd_ovr(rd_ovr_b)
    );

    generic_mem_sync_be #(.DWIDTH(64), .BWIDTH(8), .AWIDTH(4), .RAM_DEPTH(16),
                          .REGISTER_READ(1), .RDW_MODE(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .ren(ren), .raddr(raddr), .roen(roen),
        .rdata(rdata_c), .rvalid(rvalid_c), .rd_ovr(rd_ovr_c)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%016h, want 0x%016h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [63:0] d, input logic [7:0] be);
        wen   = 1'b1;
        waddr = a;
        wdata = d;
        wbe   = be;
        ren   = 1'b0;
        tick();
        wen   = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        wen   = 1'b0;
        ren   = 1'b1;
        raddr = a;
        tick();
        ren   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        wen   = 1'b0;
        waddr = '0;
        wdata = '0;
        wbe   = '0;
        ren   = 1'b0;
        raddr = '0;
        roen  = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rdata_a",  rdata_a, 64'h0);
        check_eq("rst_rvalid_a", 64'(rvalid_a), 64'h0);
        check_eq("rst_rvalid_c", 64'(rvalid_c), 64'h0);
        check_eq("rst_rd_ovr_c", 64'(rd_ovr_c), 64'h0);
        rst_n = 1'b1;
        tick();

        // full-word write and readback, latency 1
        wr(4'd3, 64'h1111_2222_3333_4444, 8'hFF);
        rd(4'd3);
        check_eq("full_rvalid_a", 64'(rvalid_a), 64'h1);
        check_eq("full_rdata_a",  rdata_a, 64'h1111_2222_3333_4444);
        tick();
        check_eq("idle_rvalid_a", 64'(rvalid_a), 64'h0);
        check_eq("idle_hold_a",   rdata_a, 64'h1111_2222_3333_4444);

        // partial lane write
        wr(4'd5, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
        wr(4'd5, 64'h0, 8'h0F);
        rd(4'd5);
        check_eq("partial_a", rdata_a, 64'hAAAA_AAAA_0000_0000);

        // read-during-write, full lanes
        wr(4'd7, 64'h00FF, 8'hFF);
        wen = 1'b1; waddr = 4'd7; wdata = 64'h1234; wbe = 8'hFF;
        ren = 1'b1; raddr = 4'd7;
        tick();
        wen = 1'b0; ren = 1'b0;
        check_eq("rdw_old_a", rdata_a, 64'h00FF);
        check_eq("rdw_new_b", rdata_b, 64'h1234);
        rd(4'd7);
        check_eq("rdw_after_a", rdata_a, 64'h1234);

        // read-during-write, single lane merged
        wr(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        wen = 1'b1; waddr = 4'd2; wdata = 64'h0; wbe = 8'h01;
        ren = 1'b1; raddr = 4'd2;
        tick();
        wen = 1'b0; ren = 1'b0;
        check_eq("rdw_merge_b", rdata_b, 64'hFFFF_FFFF_FFFF_FF00);
        check_eq("rdw_merge_old_a", rdata_a, 64'hFFFF_FFFF_FFFF_FFFF);

        // wen with no lanes enabled changes nothing
        wr(4'd2, 64'h0, 8'h00);
        rd(4'd2);
        check_eq("wbe_zero_a", rdata_a, 64'hFFFF_FFFF_FFFF_FF00);

        // out-of-range on the 12-deep instance
        wr(4'd13, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
        rd(4'd13);
        check_eq("oor_rvalid_a", 64'(rvalid_a), 64'h1);
        check_eq("oor_rdata_a",  rdata_a, 64'h0);

        // registered read: back-to-back latency and order
        wr(4'd0, 64'h10, 8'hFF);
        wr(4'd1, 64'h11, 8'hFF);
        wr(4'd2, 64'h12, 8'hFF);
        ren = 1'b1; raddr = 4'd0;
        tick();
        check_eq("lat1_rdata_a", rdata_a, 64'h10);
        check_eq("lat2_early_c", 64'(rvalid_c), 64'h0);
        raddr = 4'd1;
        tick();
        check_eq("b2b0_rvalid_c", 64'(rvalid_c), 64'h1);
        check_eq("b2b0_rdata_c",  rdata_c, 64'h10);
        raddr = 4'd2;
        tick();
        check_eq("b2b1_rdata_c", rdata_c, 64'h11);
        ren = 1'b0;
        tick();
        check_eq("b2b2_rdata_c", rdata_c, 64'h12);
        tick();
        check_eq("b2b_done_c", 64'(rvalid_c), 64'h0);

        // stall with a pending stage-1 result, then overrun
        ren = 1'b1; raddr = 4'd0;
        tick();
        raddr = 4'd1;
        tick();
        check_eq("stall_pre_c",   rdata_c, 64'h10);
        check_eq("stall_pre_ovr", 64'(rd_ovr_c), 64'h0);
        raddr = 4'd2; roen = 1'b0;
        tick();
        check_eq("ovr_set_c",    64'(rd_ovr_c), 64'h1);
        check_eq("stall_vld_c",  64'(rvalid_c), 64'h1);
        check_eq("stall_hold_c", rdata_c, 64'h10);
        check_eq("ovr_noreg_a",  64'(rd_ovr_a), 64'h0);
        ren = 1'b0; roen = 1'b1;
        tick();
        check_eq("ovr_newest_c", rdata_c, 64'h12);
        tick();
        check_eq("ovr_sticky_c", 64'(rd_ovr_c), 64'h1);
        check_eq("ovr_drain_c",  64'(rvalid_c), 64'h0);

        // async reset mid-cycle with a valid response and a read in flight
        rd(4'd1);
        check_eq("prerst_rvalid_a", 64'(rvalid_a), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_rdata_a",  rdata_a, 64'h0);
        check_eq("arst_rvalid_a", 64'(rvalid_a), 64'h0);
        check_eq("arst_rd_ovr_c", 64'(rd_ovr_c), 64'h0);
        check_eq("arst_rvalid_c", 64'(rvalid_c), 64'h0);
        #2 rst_n = 1'b1;
        tick();
        tick();
        check_eq("dropped_rd_c", 64'(rvalid_c), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
